// File: rtl/metadata_pkg.sv
// Shared types and constants for the SUMP metadata/ID sender.
// States, token bytes, ID bytes, sequence lengths, byte helper.
package metadata_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } state_t;

    localparam logic [7:0] TOK_END    = 8'h00;
    localparam logic [7:0] TOK_NAME   = 8'h01;
    localparam logic [7:0] TOK_PROBES = 8'h20;
    localparam logic [7:0] TOK_MEM    = 8'h21;
    localparam logic [7:0] TOK_RATE   = 8'h23;
    localparam logic [7:0] TOK_VER    = 8'h24;

    localparam logic [7:0] ID_B0 = 8'h31;
    localparam logic [7:0] ID_B1 = 8'h41;
    localparam logic [7:0] ID_B2 = 8'h4C;
    localparam logic [7:0] ID_B3 = 8'h53;

    localparam int ID_LEN        = 4;
    localparam int META_BASE_LEN = 21;
    localparam int NAME_LEN      = 10;
    localparam int META_NAME_LEN = META_BASE_LEN + NAME_LEN;

    // Big-endian byte k (1 = MSB .. 4 = LSB) of a 32-bit value.
    function automatic logic [7:0] be_byte(
        input logic [31:0] v,
        input logic [2:0]  k
    );
        logic [31:0] s;
        s = v >> (8 * (4 - int'(k)));
        return s[7:0];
    endfunction

endpackage

// File: rtl/metadata_rom.sv
// Byte lookup for ID and metadata streams, plus last-byte flag.
// META_NAME_EN prefixes metadata with a DEVICE_NAME record.
module metadata_rom
    import metadata_pkg::*;
#(
    parameter logic [31:0] NUM_PROBES   = 32'd32,
    parameter logic [31:0] MEM_BYTES    = 32'd16384,
    parameter logic [31:0] MAX_RATE_HZ  = 32'd100000000,
    parameter logic [31:0] PROTOCOL_VER = 32'd2,
    parameter logic [63:0] DEVICE_NAME  = 64'h4C4F474943414E41
) (
    input  logic [4:0] idx,
    input  logic       send_id,
    output logic [7:0] data,
    output logic       last
);

    logic [4:0]  off;
    logic [4:0]  pos;
    logic [7:0]  tok;
    logic [31:0] val;
    logic        in_name;
`ifdef META_NAME_EN
    logic [63:0] name_sh;
`endif

    // Map (mode, index) onto the byte to send and whether it ends the stream.
    always_comb begin
        data    = TOK_END;
        last    = 1'b0;
        off     = idx;
        pos     = '0;
        tok     = TOK_END;
        val     = '0;
        in_name = 1'b0;
`ifdef META_NAME_EN
        name_sh = '0;
`endif
        if (send_id) begin
            unique case (idx)
                5'd0:    data = ID_B0;
                5'd1:    data = ID_B1;
                5'd2:    data = ID_B2;
                default: data = ID_B3;
            endcase
            last = (idx == 5'(ID_LEN - 1));
        end else begin
`ifdef META_NAME_EN
            if (idx < 5'(NAME_LEN)) begin
                in_name = 1'b1;
                if (idx == 5'd0) begin
                    data = TOK_NAME;
                end else if (idx == 5'(NAME_LEN - 1)) begin
                    data = TOK_END;
                end else begin
                    name_sh = DEVICE_NAME >> (8 * (8 - int'(idx)));
                    data    = name_sh[7:0];
                end
            end else begin
                off = idx - 5'(NAME_LEN);
            end
`endif
            if (!in_name) begin
                unique case (1'b1)
                    (off < 5'd5): begin
                        tok = TOK_PROBES;
                        val = NUM_PROBES;
                        pos = off;
                    end
                    (off >= 5'd5 && off < 5'd10): begin
                        tok = TOK_MEM;
                        val = MEM_BYTES;
                        pos = off - 5'd5;
                    end
                    (off >= 5'd10 && off < 5'd15): begin
                        tok = TOK_RATE;
                        val = MAX_RATE_HZ;
                        pos = off - 5'd10;
                    end
                    (off >= 5'd15 && off < 5'd20): begin
                        tok = TOK_VER;
                        val = PROTOCOL_VER;
                        pos = off - 5'd15;
                    end
                    default: begin
                        last = 1'b1;
                    end
                endcase
                if (last || pos == 5'd0) begin
                    data = tok;
                end else begin
                    data = be_byte(val, pos[2:0]);
                end
            end
        end
    end

endmodule

// File: rtl/metadata_sender_param.sv
// Streams SUMP ID or metadata bytes over a tran_data/tx_busy handshake.
// Build option META_NAME_EN adds the device-name record to metadata.
module metadata_sender_param
    import metadata_pkg::*;
#(
    parameter logic [31:0] NUM_PROBES   = 32'd32,
    parameter logic [31:0] MEM_BYTES    = 32'd16384,
    parameter logic [31:0] MAX_RATE_HZ  = 32'd100000000,
    parameter logic [31:0] PROTOCOL_VER = 32'd2,
    parameter logic [63:0] DEVICE_NAME  = 64'h4C4F474943414E41,
    parameter int unsigned ACK_TIMEOUT  = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       begin_meta_transmit,
    input  logic       send_id,
    input  logic       abort,
    input  logic       tx_busy,
    output logic [7:0] transmit_byte,
    output logic       tran_data,
    output logic       meta_busy,
    output logic       meta_done
);

    localparam logic [7:0] TIMEOUT = 8'(ACK_TIMEOUT);

    state_t     state;
    logic [4:0] idx;
    logic [7:0] cnt;
    logic       mode_id;
    logic [7:0] rom_byte;
    logic       rom_last;

    metadata_rom #(
        .NUM_PROBES  (NUM_PROBES),
        .MEM_BYTES   (MEM_BYTES),
        .MAX_RATE_HZ (MAX_RATE_HZ),
        .PROTOCOL_VER(PROTOCOL_VER),
        .DEVICE_NAME (DEVICE_NAME)
    ) u_rom (
        .idx    (idx),
        .send_id(mode_id),
        .data   (rom_byte),
        .last   (rom_last)
    );

    // Handshake FSM: issue a byte, wait for busy rise (or retry), wait for busy fall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            idx           <= '0;
            cnt           <= '0;
            mode_id       <= 1'b0;
            transmit_byte <= 8'h00;
            tran_data     <= 1'b0;
            meta_busy     <= 1'b0;
            meta_done     <= 1'b0;
        end else begin
            tran_data <= 1'b0;
            meta_done <= 1'b0;
            if (state != ST_IDLE && abort) begin
                state     <= ST_IDLE;
                meta_busy <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (begin_meta_transmit && !abort) begin
                            mode_id   <= send_id;
                            idx       <= '0;
                            state     <= ST_ISSUE;
                            meta_busy <= 1'b1;
                        end
                    end
                    ST_ISSUE: begin
                        if (!tx_busy) begin
                            tran_data     <= 1'b1;
                            transmit_byte <= rom_byte;
                            cnt           <= '0;
                            state         <= ST_WAIT_ACK;
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (tx_busy) begin
                            state <= ST_WAIT_DONE;
                        end else if (cnt == TIMEOUT) begin
                            state <= ST_ISSUE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (!tx_busy) begin
                            if (rom_last) begin
                                state     <= ST_IDLE;
                                meta_busy <= 1'b0;
                                meta_done <= 1'b1;
                            end else begin
                                idx   <= idx + 5'd1;
                                state <= ST_ISSUE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_metadata_sender_param.sv
// Randomized self-checking bench for metadata_sender_param.
// Honours META_NAME_EN the same way as the design.
module tb_metadata_sender_param;

    localparam logic [31:0] P_PROBES = 32'd32;
    localparam logic [31:0] P_MEM    = 32'd16384;
    localparam logic [31:0] P_RATE   = 32'd100000000;
    localparam logic [31:0] P_VER    = 32'd2;
    localparam logic [63:0] P_NAME   = 64'h4C4F474943414E41;
    localparam int          P_TO     = 15;

    typedef logic [7:0] bq_t[$];

    logic       clock;
    logic       reset;
    logic       begin_meta_transmit;
    logic       send_id;
    logic       abort;
    logic       tx_busy;
    logic [7:0] transmit_byte;
    logic       tran_data;
    logic       meta_busy;
    logic       meta_done;

    int total = 0;
    int bad = 0;

    metadata_sender_param #(
        .NUM_PROBES  (P_PROBES),
        .MEM_BYTES   (P_MEM),
        .MAX_RATE_HZ (P_RATE),
        .PROTOCOL_VER(P_VER),
        .DEVICE_NAME (P_NAME),
        .ACK_TIMEOUT (P_TO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .begin_meta_transmit(begin_meta_transmit),
        .send_id            (send_id),
        .abort              (abort),
        .tx_busy            (tx_busy),
        .transmit_byte      (transmit_byte),
        .tran_data          (tran_data),
        .meta_busy          (meta_busy),
        .meta_done          (meta_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic bq_t build_seq(input bit id);
        bq_t q;
        logic [31:0] vals [4];
        logic [7:0]  toks [4];
        logic [63:0] nm;
        q = {};
        if (id) begin
            q = '{8'h31, 8'h41, 8'h4C, 8'h53};
            return q;
        end
`ifdef META_NAME_EN
        nm = P_NAME;
        q.push_back(8'h01);
        for (int i = 0; i < 8; i++) q.push_back(8'((nm >> (56 - 8 * i)) & 64'hFF));
        q.push_back(8'h00);
`else
        nm = '0;
`endif
        toks = '{8'h20, 8'h21, 8'h23, 8'h24};
        vals = '{P_PROBES, P_MEM, P_RATE, P_VER};
        for (int t = 0; t < 4; t++) begin
            q.push_back(toks[t]);
            for (int b = 3; b >= 0; b--) q.push_back(8'((vals[t] >> (8 * b)) & 32'hFF));
        end
        q.push_back(8'h00);
        return q;
    endfunction

    // transmitter model: accepts or drops strobes, drives tx_busy
    int   pc = 0;
    bq_t  rx;
    int   tx_delay = 1;
    int   tx_len = 10;
    int   drop_left = 0;
    int   drop_idx = 0;
    bit   spacing_chk = 0;
    bit   have_drop = 0;
    int   drop_cyc = 0;

    always @(posedge clock) pc <= pc + 1;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (tran_data) begin
                if (spacing_chk && have_drop && rx.size() == drop_idx) begin
                    chk("retry_spacing", 32'(pc - drop_cyc), 32'd17);
                    have_drop = 0;
                end
                if (drop_left > 0 && rx.size() == drop_idx) begin
                    drop_left--;
                    have_drop = 1;
                    drop_cyc = pc;
                end else begin
                    rx.push_back(transmit_byte);
                    repeat (tx_delay) begin
                        @(posedge clock);
                        #1;
                    end
                    tx_busy = 1'b1;
                    repeat (tx_len) begin
                        @(posedge clock);
                        #1;
                    end
                    tx_busy = 1'b0;
                end
            end
        end
    end

    // reference model and per-cycle compare
    bit   m_active = 0;
    int   m_phase = 0;
    int   m_n = 0;
    int   m_strobe_at = 0;
    int   ec = 0;
    bq_t  m_seq;
    bq_t  last_rx;
    logic [7:0] exp_byte = 8'h00;
    bit   exp_strobe;
    bit   exp_done;
    int   done_cnt = 0;
    logic p_reset = 1'b0;
    logic p_begin = 1'b0;
    logic p_abort = 1'b0;
    logic p_id = 1'b0;
    logic p_txb = 1'b0;

    always @(negedge clock) begin
        ec++;
        exp_strobe = 0;
        exp_done = 0;
        if (!reset) begin
            m_active = 0;
            exp_byte = 8'h00;
            rx.delete();
            chk("rst_byte", 32'(transmit_byte), 32'h0);
            chk("rst_tran", 32'(tran_data), 32'h0);
            chk("rst_busy", 32'(meta_busy), 32'h0);
            chk("rst_done", 32'(meta_done), 32'h0);
        end else begin
            if (p_reset) begin
                if (m_active) begin
                    if (p_abort) begin
                        m_active = 0;
                        rx.delete();
                    end else if (m_phase == 0) begin
                        if (!p_txb) begin
                            exp_strobe = 1;
                            exp_byte = m_seq[m_n];
                            m_strobe_at = ec;
                            m_phase = 1;
                        end
                    end else if (m_phase == 1) begin
                        if (p_txb) m_phase = 2;
                        else if (ec - m_strobe_at == P_TO + 1) m_phase = 0;
                    end else begin
                        if (!p_txb) begin
                            if (m_n == m_seq.size() - 1) begin
                                m_active = 0;
                                exp_done = 1;
                            end else begin
                                m_n++;
                                m_phase = 0;
                            end
                        end
                    end
                end else if (p_begin && !p_abort) begin
                    m_active = 1;
                    m_seq = build_seq(p_id);
                    m_n = 0;
                    m_phase = 0;
                end
            end
            chk("meta_busy", 32'(meta_busy), 32'(m_active));
            chk("tran_data", 32'(tran_data), 32'(exp_strobe));
            chk("meta_done", 32'(meta_done), 32'(exp_done));
            chk("transmit_byte", 32'(transmit_byte), 32'(exp_byte));
            if (exp_done) begin
                chk("rx_len", 32'(rx.size()), 32'(m_seq.size()));
                for (int i = 0; i < rx.size() && i < m_seq.size(); i++)
                    if (rx[i] !== m_seq[i])
                        chk($sformatf("rx_byte%0d", i), 32'(rx[i]), 32'(m_seq[i]));
                last_rx = rx;
                rx.delete();
                done_cnt++;
            end
        end
        p_reset = reset;
        p_begin = begin_meta_transmit;
        p_abort = abort;
        p_id    = send_id;
        p_txb   = tx_busy;
    end

    task automatic run_stream(input bit id, input int abort_at, input bit noise,
                              input bit check_first);
        int cyc;
        @(posedge clock);
        #1;
        send_id = id;
        begin_meta_transmit = 1'b1;
        cyc = 0;
        do begin
            @(posedge clock);
            #1;
            if (check_first && cyc == 0) chk("busy_after_start", 32'(meta_busy), 32'h1);
            if (check_first && cyc == 1) chk("first_strobe", 32'(tran_data), 32'h1);
            begin_meta_transmit = noise && ($urandom_range(0, 29) == 0);
            send_id = 1'($urandom_range(0, 1));
            abort = (cyc == abort_at);
            cyc++;
        end while (meta_busy && cyc < 3000);
        begin_meta_transmit = 1'b0;
        abort = 1'b0;
        if (cyc >= 3000) chk("stream_timeout", 32'(cyc), 32'd0);
    endtask

    bq_t lit;
    int  d0;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        begin_meta_transmit = 1'b0;
        send_id = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);

        // ID stream
        d0 = done_cnt;
        tx_delay = 1;
        tx_len = 10;
        run_stream(1'b1, -1, 1'b0, 1'b1);
        repeat (3) @(posedge clock);
        chk("id_done_count", 32'(done_cnt - d0), 32'd1);
        lit = '{8'h31, 8'h41, 8'h4C, 8'h53};
        chk("id_len", 32'(last_rx.size()), 32'd4);
        for (int i = 0; i < 4 && i < last_rx.size(); i++)
            chk($sformatf("id_lit%0d", i), 32'(last_rx[i]), 32'(lit[i]));
        #1;
        chk("id_idle_busy", 32'(meta_busy), 32'h0);

        // metadata stream, literal pins
        run_stream(1'b0, -1, 1'b0, 1'b1);
        repeat (3) @(posedge clock);
        lit = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h20, 8'h21, 8'h00, 8'h00, 8'h40,
                8'h00, 8'h23, 8'h05, 8'hF5, 8'hE1, 8'h00, 8'h24, 8'h00, 8'h00,
                8'h00, 8'h02, 8'h00};
`ifdef META_NAME_EN
        lit = {'{8'h01, 8'h4C, 8'h4F, 8'h47, 8'h49, 8'h43, 8'h41, 8'h4E, 8'h41,
                 8'h00}, lit};
`endif
        chk("meta_len", 32'(last_rx.size()), 32'(lit.size()));
        for (int i = 0; i < lit.size() && i < last_rx.size(); i++)
            chk($sformatf("meta_lit%0d", i), 32'(last_rx[i]), 32'(lit[i]));

        // timeout and retry on byte 2
        drop_idx = 2;
        drop_left = 2;
        spacing_chk = 1;
        d0 = done_cnt;
        run_stream(1'b1, -1, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        spacing_chk = 0;
        have_drop = 0;
        chk("retry_done", 32'(done_cnt - d0), 32'd1);
        chk("retry_rx_len", 32'(last_rx.size()), 32'd4);

        // abort mid-stream, then restart
        d0 = done_cnt;
        @(posedge clock);
        #1;
        send_id = 1'b0;
        begin_meta_transmit = 1'b1;
        @(posedge clock);
        #1;
        begin_meta_transmit = 1'b0;
        for (int c = 0; c < 2000 && rx.size() < 5; c++) @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        chk("abort_busy", 32'(meta_busy), 32'h0);
        repeat (40) @(posedge clock);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_stream(1'b1, -1, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        chk("restart_first", 32'(last_rx.size() > 0 ? last_rx[0] : 8'hFF), 32'h31);

        // abort and start together in idle
        @(posedge clock);
        #1;
        begin_meta_transmit = 1'b1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        begin_meta_transmit = 1'b0;
        abort = 1'b0;
        chk("abort_start_idle", 32'(meta_busy), 32'h0);

        // reset mid-stream with start held
        d0 = done_cnt;
        send_id = 1'b0;
        begin_meta_transmit = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        reset = 1'b0;
        begin_meta_transmit = 1'b0;
        #1;
        chk("async_rst_busy", 32'(meta_busy), 32'h0);
        chk("async_rst_byte", 32'(transmit_byte), 32'h0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (40) @(posedge clock);
        chk("rst_no_done", 32'(done_cnt - d0), 32'd0);

        // randomized streams
        for (int it = 0; it < 16; it++) begin
            tx_delay = $urandom_range(0, 4);
            tx_len = $urandom_range(1, 6);
            drop_idx = $urandom_range(0, 3);
            drop_left = $urandom_range(0, 2);
            run_stream(1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 60)) : -1,
                       1'b1, 1'b0);
            drop_left = 0;
            repeat (tx_delay + tx_len + 2) @(posedge clock);
        end

        repeat (5) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/metadata_sender_param.md
# metadata_sender_param

Parametrised SUMP-style metadata/ID transmitter that sits between the command decoder and the UART transmitter. On request it streams either the 4-byte device ID or a key/value metadata block built from elaboration-time parameters (probe count, memory size, sample rate, protocol version) one byte at a time over a `tran_data`/`tx_busy` handshake. It adds per-byte acknowledge timeout with retry, abort, and a completion pulse.

## Interface
- `NUM_PROBES`, 32: probe count, token 0x20.
- `MEM_BYTES`, 16384: sample memory size in bytes, token 0x21.
- `MAX_RATE_HZ`, 100000000: max sample rate, token 0x23.
- `PROTOCOL_VER`, 2: protocol version, token 0x24.
- `DEVICE_NAME`, 64'h4C4F474943414E41 ("LOGICANA"): 8 ASCII chars, MSB char first; used only with `META_NAME_EN`.
- `ACK_TIMEOUT`, 15: cycles to wait for `tx_busy` rise before re-issuing a byte; 1..255.

- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `begin_meta_transmit` in 1: start request, sampled in IDLE only.
- `send_id` in 1: 1 = send ID, 0 = send metadata; sampled with `begin_meta_transmit`.
- `abort` in 1: cancel stream in progress.
- `tx_busy` in 1: transmitter busy.
- `transmit_byte` out 8: byte to transmit.
- `tran_data` out 1: one-cycle transmit strobe.
- `meta_busy` out 1: high from accepted start until stream end/abort.
- `meta_done` out 1: one-cycle pulse on normal completion.

## Operation
- ID sequence (4 bytes): 0x31, 0x41, 0x4C, 0x53 ("1ALS").
- Metadata sequence (21 bytes): 0x20, NUM_PROBES[31:0]; 0x21, MEM_BYTES; 0x23, MAX_RATE_HZ; 0x24, PROTOCOL_VER; each value 4 bytes big-endian; terminator 0x00.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE: `begin_meta_transmit`=1 and `abort`=0 -> latch `send_id`, index=0, ISSUE, `meta_busy`=1.
- ISSUE: `tx_busy`=0 -> `tran_data`=1 for one cycle, `transmit_byte`=byte[index], timeout counter cleared, WAIT_ACK; `tx_busy`=1 -> hold.
- WAIT_ACK: `tx_busy`=1 -> WAIT_DONE; counter reaches ACK_TIMEOUT -> ISSUE (same index, re-sent).
- WAIT_DONE: `tx_busy`=0 -> last byte: IDLE, `meta_busy`=0, `meta_done`=1 one cycle; else index+1, ISSUE.
- `abort`=1 in any non-IDLE state -> IDLE next edge; `tran_data`=0, `meta_busy`=0, no `meta_done`.
- `begin_meta_transmit` outside IDLE ignored; `send_id` changes mid-stream ignored.
- Index 5 bits, never exceeds sequence length-1; no wrap.

## Timing
- All outputs registered. Reset: `transmit_byte`=0x00, `tran_data`=0, `meta_busy`=0, `meta_done`=0, state IDLE, index 0, counter 0.
- Start sampled at edge N -> `meta_busy` high after N; first `tran_data` after N+1 if `tx_busy` low.
- `transmit_byte` holds from its strobe until the next strobe; unchanged on return to IDLE.
- Reset asserted mid-stream: immediate return to reset values; no partial resume.
- `abort` and `begin_meta_transmit` together in IDLE: no start.
- `meta_done` and `meta_busy` fall on the same edge.

## Configuration
- `META_NAME_EN` defined: metadata prefixed with 0x01, 8 DEVICE_NAME bytes, 0x00 (10 bytes); total 31 bytes. ID sequence unchanged.
- Undefined: 21-byte metadata as above; DEVICE_NAME unused.

## Structure
- Package `metadata_pkg`: state enum, token constants (0x00, 0x01, 0x20, 0x21, 0x23, 0x24), ID byte constants, sequence-length constants.
- Sub-module `metadata_rom`: combinational, inputs index + mode, outputs byte and last flag; parameters passed through; owns `META_NAME_EN` handling.

## Test plan
- ID mode: start with `send_id`=1, `tx_busy` model raising 1 cycle after strobe for 10 cycles -> bytes 0x31,0x41,0x4C,0x53, one `meta_done`, `meta_busy` low afterwards.
- Metadata defaults: `send_id`=0 -> 21 bytes: 0x20,00,00,00,20,0x21,00,00,40,00,0x23,05,F5,E1,00,0x24,00,00,00,02,0x00.
- Timeout: `tx_busy` never rises for byte 2 -> byte 2 re-strobed every 17 cycles; releasing model completes sequence with no byte skipped or duplicated downstream.
- Abort at byte 5 -> `meta_busy` low next cycle, no `meta_done`, no further `tran_data`; new start restarts at byte 0.
- Reset low mid-stream, start held during stream -> outputs zero immediately; held start during busy produces no second stream.
- `META_NAME_EN` build -> 31 bytes starting 0x01,'L','O','G','I','C','A','N','A',0x00,0x20.
